rr_onehot_arbiter: RTL and testbench
====================================

RR_ONEHOT_ARBITER -- requirements
Module: rr_onehot_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- N_REQ, 4, number of requesters.
- DATA_W, 2, requester data width.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  N_REQ  request per requester; held high until acked.
- idata0..idata3  input  DATA_W each  requester data.
- ack  output  N_REQ  one-hot, combinational; marks the transfer cycle of the granted requester.
- grant  output  N_REQ  registered one-hot grant, or zero; drives the downstream one-hot mux select.
- odata  output  DATA_W  registered data of the granted requester.
- ovalid  output  1  odata/grant valid.
- oready  input  1  downstream accepts odata.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.

Function
REQ-004 The FSM SHALL have two states: IDLE (grant=0, ovalid=0) and GRANT (grant one-hot, ovalid=1).
REQ-005 grant SHALL always be one-hot in GRANT and zero in IDLE; no other value is legal.
REQ-006 IDLE->GRANT: if any req bit is high at a clock edge, grant and odata SHALL update at that edge.
- grant SHALL be the first requester at or after ptr, in circular order.
- odata SHALL be that requester's idata.
- Latency from req to ovalid SHALL be 1 cycle.
REQ-007 A transfer SHALL occur in any cycle with ovalid=1 and oready=1.
- ack SHALL equal grant in that cycle and zero in every other cycle.
REQ-008 While ovalid=1 and oready=0, grant, odata and ptr SHALL stay unchanged, whatever req and idata do.
REQ-009 On transfer, ptr SHALL become (granted index + 1) mod N_REQ.
REQ-010 On transfer, the next grant SHALL be chosen from req & ~grant using the new ptr.
- If the set is non-empty, the FSM SHALL stay in GRANT with the new grant and data at the next edge.
- This gives back-to-back transfers with no bubble.
- If the set is empty, the FSM SHALL go to IDLE.
REQ-011 If the granted requester drops req before its ack, grant SHALL remain until transfer (sticky grant).
REQ-012 With all N_REQ requests held high continuously and oready=1, grants SHALL rotate 0,1,2,3,0,...
- Each grant SHALL last one cycle.
- No requester SHALL wait more than N_REQ-1 transfers.
REQ-013 ptr SHALL be a $clog2(N_REQ)-bit index.
- Wrap from N_REQ-1 to 0 SHALL be modular.
- ptr SHALL NOT change in IDLE.
REQ-014 In an IDLE cycle with no requests, all outputs SHALL hold their reset values except odata.
- odata SHALL hold the last transferred value.

Reset
REQ-015 When rst_n is low at a rising edge, the block SHALL set:
- state=IDLE, grant=0, ovalid=0, odata=0, ptr=0.
REQ-016 ack SHALL be 0 while rst_n is low.
REQ-017 Reset asserted during GRANT SHALL drop the pending transfer; no ack SHALL be issued for it.
REQ-018 The first edge with rst_n high SHALL evaluate req per REQ-006.

Structure
REQ-019 Package rr_arb_pkg SHALL hold:
- N_REQ and DATA_W default constants.
- state_t enum {IDLE, GRANT}.
REQ-020 The circular priority pick SHALL be a combinational sub-module, rr_onehot_pick.
- Inputs: request vector, ptr.
- Output: one-hot pick, zero when no request.
- It SHALL be instantiated once.
REQ-021 Data selection SHALL be a one-hot AND-OR of idata0..idata3 under the picked vector.

Verification
REQ-022 Reset: rst_n=0 for 2 cycles with req=4'b1111 -> grant=0, ovalid=0, odata=0, ack=0; first edge after release -> grant=4'b0001.
REQ-023 Rotation: idata0..3 = 00,01,10,11; req=4'b1111; oready=1 -> grant sequence 0001,0010,0100,1000,0001; odata sequence 00,01,10,11,00; ack one cycle per grant.
REQ-024 Stall: req=4'b0100, oready=0 for 3 cycles -> grant=4'b0100 and odata=10 stable, ack=0; oready=1 -> ack=4'b0100 that cycle; next cycle IDLE.
REQ-025 Skip and wrap: ptr=3 after granting requester 2; req=4'b0011 -> grant=4'b0001, then 4'b0010; ptr ends at 2.
REQ-026 Sticky and mid-reset: grant=4'b1000, req drops to 0 with oready=0 -> grant held; rst_n=0 at the next edge -> grant=0, ovalid=0, no ack issued.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Purpose: shared constants and state encoding for the round-robin one-hot arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DEF_N_REQ  - default number of requesters
//   DEF_DATA_W - default requester data width
//   state_t    - arbiter FSM state (IDLE, GRANT)
package rr_arb_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : rr_arb_pkg

// File: rtl/rr_onehot_pick.sv
// Purpose: circular priority pick - first set request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
//
// Ports:
//   req  [N_REQ-1:0] - candidate request vector
//   ptr  [PTR_W-1:0] - index with highest priority this evaluation
//   pick [N_REQ-1:0] - one-hot winner, all zero when req is zero
module rr_onehot_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Walk the requesters starting at ptr; the modulo keeps the wrap correct
  // even when N_REQ is not a power of two.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule : rr_onehot_pick

// File: rtl/rr_onehot_arbiter.sv
// Purpose: round-robin arbiter with registered one-hot grant and registered data.
// Latency: 1 cycle req -> ovalid; back-to-back grants with no bubble.
// Backpressure: ovalid && !oready freezes grant, odata and ptr until accepted.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   req [N_REQ-1:0]       - per-requester request, held until acked
//   idata0..idata3        - per-requester data
//   ack [N_REQ-1:0]       - combinational one-hot, high in the transfer cycle
//   grant [N_REQ-1:0]     - registered one-hot grant (zero when idle)
//   odata [DATA_W-1:0]    - registered data of the granted requester
//   ovalid / oready       - output handshake
module rr_onehot_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] idata0,
  input  logic [DATA_W-1:0] idata1,
  input  logic [DATA_W-1:0] idata2,
  input  logic [DATA_W-1:0] idata3,
  output logic [N_REQ-1:0]  ack,
  output logic [N_REQ-1:0]  grant,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  input  logic              oready
);

  localparam int PTR_W = $clog2(N_REQ);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic [PTR_W-1:0]  gidx;
  logic [PTR_W-1:0]  ptr_after;
  logic [PTR_W-1:0]  pick_ptr;
  logic [N_REQ-1:0]  pick_req;
  logic [N_REQ-1:0]  pick;
  logic [DATA_W-1:0] pick_data;
  logic [DATA_W-1:0] idata_arr [4];
  logic              xfer;

  assign idata_arr[0] = idata0;
  assign idata_arr[1] = idata1;
  assign idata_arr[2] = idata2;
  assign idata_arr[3] = idata3;

  assign ovalid = (state_q == GRANT);
  assign grant  = grant_q;
  assign odata  = odata_q;
  assign xfer   = ovalid && oready;

  // Reset kills the pending transfer, so ack is suppressed while rst_n is low.
  assign ack = (rst_n && xfer) ? grant_q : '0;

  // Index of the current grant; grant_q is one-hot whenever this is used.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) gidx = PTR_W'(i);
    end
  end

  assign ptr_after = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;

  // In GRANT the picker looks ahead to the post-transfer choice so the next
  // grant can load on the same edge as the transfer. The current winner is
  // masked out because its req is still high during its own ack cycle.
  assign pick_req = (state_q == GRANT) ? (req & ~grant_q) : req;
  assign pick_ptr = (state_q == GRANT) ? ptr_after : ptr_q;

  rr_onehot_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req  (pick_req),
    .ptr  (pick_ptr),
    .pick (pick)
  );

  // One-hot AND-OR data select under the picked vector.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_data = pick_data | ({DATA_W{pick[i]}} & idata_arr[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    odata_d = odata_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          grant_d = pick;
          odata_d = pick_data;
        end
      end
      GRANT: begin
        // Without a transfer everything holds, which also makes the grant
        // sticky if the winner drops req early.
        if (xfer) begin
          ptr_d = ptr_after;
          if (|pick) begin
            grant_d = pick;
            odata_d = pick_data;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      odata_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      odata_q <= odata_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule : rr_onehot_arbiter

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: reset, rotation, stall, skip/wrap,
// sticky grant and mid-grant reset, with hand-computed expected values.
module tb_rr_onehot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] idata0, idata1, idata2, idata3;
  logic [3:0] ack;
  logic [3:0] grant;
  logic [1:0] odata;
  logic       ovalid;
  logic       oready;

  int n_chk  = 0;
  int n_fail = 0;

  rr_onehot_arbiter #(
    .N_REQ  (4),
    .DATA_W (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .idata0 (idata0),
    .idata1 (idata1),
    .idata2 (idata2),
    .idata3 (idata3),
    .ack    (ack),
    .grant  (grant),
    .odata  (odata),
    .ovalid (ovalid),
    .oready (oready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_grant,
                         input logic [1:0] e_odata, input logic e_ovalid,
                         input logic [3:0] e_ack);
    chk({tag, ".grant"},  8'(grant),  8'(e_grant));
    chk({tag, ".odata"},  8'(odata),  8'(e_odata));
    chk({tag, ".ovalid"}, 8'(ovalid), 8'(e_ovalid));
    chk({tag, ".ack"},    8'(ack),    8'(e_ack));
  endtask

  initial begin
    // Reset held for two edges with all requests high.
    rst_n  = 1'b0;
    req    = 4'b1111;
    idata0 = 2'b00;
    idata1 = 2'b01;
    idata2 = 2'b10;
    idata3 = 2'b11;
    oready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    chk_all("reset", 4'b0000, 2'b00, 1'b0, 4'b0000);

    // Release: first edge grants requester 0, then rotation 1,2,3,0.
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk_all("rot0", 4'b0001, 2'b00, 1'b1, 4'b0001);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      chk_all($sformatf("rot%0d", k), 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 4'(1 << (k % 4)));
    end

    // Drain: requests drop, last transfer happens, go idle with odata held.
    req = 4'b0000;
    @(negedge clk); #1;
    chk_all("idle", 4'b0000, 2'b00, 1'b0, 4'b0000);

    // Stall: requester 2 alone with oready low; ptr=1 so pick is 2.
    req    = 4'b0100;
    oready = 1'b0;
    @(negedge clk); #1;
    chk_all("stall0", 4'b0100, 2'b10, 1'b1, 4'b0000);
    idata2 = 2'b01;
    req    = 4'b1111;
    @(negedge clk); #1;
    chk_all("stall1", 4'b0100, 2'b10, 1'b1, 4'b0000);
    idata2 = 2'b10;
    req    = 4'b0100;
    @(negedge clk); #1;
    chk_all("stall2", 4'b0100, 2'b10, 1'b1, 4'b0000);
    oready = 1'b1;
    #1;
    chk("stall_rel.ack", 8'(ack), 8'(4'b0100));
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk_all("stall_idle", 4'b0000, 2'b10, 1'b0, 4'b0000);

    // Skip and wrap: ptr=3, req=0011 -> 0 (wrap) then 1.
    req = 4'b0011;
    @(negedge clk); #1;
    chk_all("wrap0", 4'b0001, 2'b00, 1'b1, 4'b0001);
    @(negedge clk);
    req = 4'b0010;
    #1;
    chk_all("wrap1", 4'b0010, 2'b01, 1'b1, 4'b0010);
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk_all("wrap_idle", 4'b0000, 2'b01, 1'b0, 4'b0000);

    // ptr should now be 2: all requests -> requester 2 first, then 3.
    req = 4'b1111;
    @(negedge clk); #1;
    chk_all("ptr2", 4'b0100, 2'b10, 1'b1, 4'b0100);
    @(negedge clk);
    // Sticky: winner 3 drops req while stalled.
    req    = 4'b0000;
    oready = 1'b0;
    #1;
    chk_all("sticky0", 4'b1000, 2'b11, 1'b1, 4'b0000);
    @(negedge clk); #1;
    chk_all("sticky1", 4'b1000, 2'b11, 1'b1, 4'b0000);

    // Mid-grant reset: oready rises together with reset, no ack allowed.
    rst_n  = 1'b0;
    oready = 1'b1;
    #1;
    chk("midrst.ack", 8'(ack), 8'(4'b0000));
    @(negedge clk); #1;
    chk_all("midrst", 4'b0000, 2'b00, 1'b0, 4'b0000);

    // Idle after release with no requests stays at reset values.
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk_all("post_idle", 4'b0000, 2'b00, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_rr_onehot_arbiter
